// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: op codes and the
// polynomial low-field successor function.
package pc_seq_pkg;

  localparam logic [2:0] OP_NEXT  = 3'b000;
  localparam logic [2:0] OP_SKIP  = 3'b001;
  localparam logic [2:0] OP_JMP   = 3'b010;
  localparam logic [2:0] OP_CALL  = 3'b011;
  localparam logic [2:0] OP_RET   = 3'b100;
  localparam logic [2:0] OP_RETSK = 3'b101;
  localparam logic [2:0] OP_SETPG = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;

  localparam int LFSR_MAX_W = 32;

  // Shift right, feeding XNOR of bit 0 and bit 'tap' into the top bit of a
  // w-wide field. Callers zero-extend the field and truncate the result.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] pl,
    input int unsigned           w,
    input int unsigned           tap
  );
    logic [LFSR_MAX_W-1:0] mask;
    logic                  fb;
    mask = LFSR_MAX_W'(1) | (LFSR_MAX_W'(1) << tap);
    fb   = ~(^(pl & mask));
    return (pl >> 1) | (LFSR_MAX_W'(fb) << (w - 1));
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO; entry 0 is the top. On a full push either the oldest
// entry falls off the bottom (OVF_MODE 0) or the push is refused (OVF_MODE 1).
module pc_ret_stack #(
  parameter  int W        = 10,
  parameter  int DEPTH    = 4,
  parameter  int OVF_MODE = 0,
  localparam int DW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  top,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [DW-1:0] depth_q, depth_d;

  assign full  = (depth_q == DW'(DEPTH));
  assign empty = (depth_q == '0);
  assign top   = empty ? '0 : mem_q[0];
  assign depth = depth_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    mem_d   = mem_q;
    depth_d = depth_q;
    if (push && !(full && OVF_MODE == 1)) begin
      mem_d[0] = din;
      for (int i = 1; i < DEPTH; i++) mem_d[i] = mem_q[i-1];
      if (!full) depth_d = depth_q + DW'(1);
    end else if (pop && !empty) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
      mem_d[DEPTH-1] = '0;
      depth_d        = depth_q - DW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the stack is a handful of flops, so it is cleared on reset like any other state.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      depth_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      mem_q   <= mem_d;
      depth_q <= depth_d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with polynomial low field, page register and return stack,
// driven one op per adv cycle from instruction decode.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter  int              PL_W      = 6,
  parameter  int              PU_W      = 4,
  parameter  int              TAP       = 1,
  parameter  int              DEPTH     = 4,
  parameter  logic [PU_W-1:0] CALL_PAGE = '1,
  parameter  int              OVF_MODE  = 0,
  localparam int              PC_W      = PL_W + PU_W,
  localparam int              DW        = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            adv,
  input  logic [2:0]      op,
  input  logic [PL_W-1:0] tgt_pl,
  input  logic [PU_W-1:0] tgt_pu,
  input  logic            clr_err,
  output logic [PC_W-1:0] pc,
  output logic [DW-1:0]   depth,
  output logic            stk_ovf,
  output logic            stk_unf,
  output logic            page_pend
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PU_W-1:0] page_q, page_d;
  logic            page_pend_q, page_pend_d;
  logic            stk_ovf_q, stk_ovf_d;
  logic            stk_unf_q, stk_unf_d;

  logic            push, pop, stk_full, stk_empty;
  logic [PC_W-1:0] stk_top, ret_addr;
  logic [PU_W-1:0] pg;

  // Low field steps through the polynomial sequence; the page never carries.
  function automatic logic [PC_W-1:0] nxt(input logic [PC_W-1:0] x);
    return {x[PC_W-1:PL_W],
            PL_W'(lfsr_next(LFSR_MAX_W'(x[PL_W-1:0]), PL_W, TAP))};
  endfunction

  assign ret_addr = nxt(pc_q);
  assign pg = page_pend_q      ? page_q    :
              (op == OP_CALL)  ? CALL_PAGE : pc_q[PC_W-1:PL_W];

  pc_ret_stack #(
    .W       (PC_W),
    .DEPTH   (DEPTH),
    .OVF_MODE(OVF_MODE)
  ) u_stack (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (ret_addr),
    .top  (stk_top),
    .depth(depth),
    .full (stk_full),
    .empty(stk_empty)
  );

  always_comb begin
    pc_d        = pc_q;
    page_d      = page_q;
    page_pend_d = page_pend_q;
    push        = 1'b0;
    pop         = 1'b0;
    // A same-cycle error below overrides the clear.
    stk_ovf_d   = stk_ovf_q & ~clr_err;
    stk_unf_d   = stk_unf_q & ~clr_err;
    if (adv) begin
      page_pend_d = 1'b0;
      case (op)
        OP_SKIP: pc_d = nxt(nxt(pc_q));
        OP_JMP:  pc_d = {pg, tgt_pl};
        OP_CALL: begin
          push = 1'b1;
          pc_d = {pg, tgt_pl};
          if (stk_full) stk_ovf_d = 1'b1;
        end
        OP_RET, OP_RETSK: begin
          pop  = 1'b1;
          pc_d = (op == OP_RETSK) ? nxt(stk_top) : stk_top;
          if (stk_empty) stk_unf_d = 1'b1;
        end
        OP_SETPG: begin
          page_d      = tgt_pu;
          page_pend_d = 1'b1;
          pc_d        = nxt(pc_q);
        end
        default: pc_d = nxt(pc_q);
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= '0;
      page_q      <= '0;
      page_pend_q <= 1'b0;
      stk_ovf_q   <= 1'b0;
      stk_unf_q   <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      page_q      <= page_d;
      page_pend_q <= page_pend_d;
      stk_ovf_q   <= stk_ovf_d;
      stk_unf_q   <= stk_unf_d;
    end
  end

  assign pc        = pc_q;
  assign stk_ovf   = stk_ovf_q;
  assign stk_unf   = stk_unf_q;
  assign page_pend = page_pend_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Drives an OVF_MODE 0 and an OVF_MODE 1 sequencer with the same op stream
// and compares both against a queue-based reference model.
module tb_pc_sequencer;

  localparam int PL_W  = 6;
  localparam int PU_W  = 4;
  localparam int TAP   = 1;
  localparam int DEPTH = 4;
  localparam int CPAGE = 15;

  localparam logic [2:0] NEXT = 3'd0, SKIP = 3'd1, JMP = 3'd2, CALL = 3'd3;
  localparam logic [2:0] RET  = 3'd4, RETSK = 3'd5, SETPG = 3'd6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       adv = 1'b0;
  logic [2:0] op = 3'd0;
  logic [5:0] tgt_pl = 6'd0;
  logic [3:0] tgt_pu = 4'd0;
  logic       clr_err = 1'b0;

  logic [9:0] pc_o    [2];
  logic [2:0] depth_o [2];
  logic       ovf_o   [2];
  logic       unf_o   [2];
  logic       pend_o  [2];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: pc as page/low integers, stack as queue (front = top).
  int m_pl [2];
  int m_pu [2];
  int stk  [2][$];
  bit m_ovf [2];
  bit m_unf [2];
  bit m_pend;
  int m_page;
  int ret_at [5];

  always #5 clk = ~clk;

  pc_sequencer #(.OVF_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .adv(adv), .op(op), .tgt_pl(tgt_pl), .tgt_pu(tgt_pu),
    .clr_err(clr_err), .pc(pc_o[0]), .depth(depth_o[0]), .stk_ovf(ovf_o[0]),
    .stk_unf(unf_o[0]), .page_pend(pend_o[0])
  );

  pc_sequencer #(.OVF_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .adv(adv), .op(op), .tgt_pl(tgt_pl), .tgt_pu(tgt_pu),
    .clr_err(clr_err), .pc(pc_o[1]), .depth(depth_o[1]), .stk_ovf(ovf_o[1]),
    .stk_unf(unf_o[1]), .page_pend(pend_o[1])
  );

  function automatic int nx(input int pl);
    int fb;
    fb = 1 - ((pl & 1) ^ ((pl >> TAP) & 1));
    return (pl >> 1) + fb * (1 << (PL_W - 1));
  endfunction

  function automatic int m_pc(input int m);
    return m_pu[m] * (1 << PL_W) + m_pl[m];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("pc.m%0d", m),    32'(pc_o[m]),    32'(m_pc(m)));
      check($sformatf("depth.m%0d", m), 32'(depth_o[m]), 32'(stk[m].size()));
      check($sformatf("ovf.m%0d", m),   32'(ovf_o[m]),   32'(m_ovf[m]));
      check($sformatf("unf.m%0d", m),   32'(unf_o[m]),   32'(m_unf[m]));
      check($sformatf("pend.m%0d", m),  32'(pend_o[m]),  32'(m_pend));
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_pl[m] = 0; m_pu[m] = 0; m_ovf[m] = 0; m_unf[m] = 0;
      stk[m].delete();
    end
    m_pend = 0;
    m_page = 0;
  endtask

  task automatic model_step(input bit a, input int o, input int tpl, input int tpu, input bit c);
    for (int m = 0; m < 2; m++) begin
      int r, pg_jmp, pg_call;
      if (c) begin m_ovf[m] = 0; m_unf[m] = 0; end
      if (!a) continue;
      pg_jmp  = m_pend ? m_page : m_pu[m];
      pg_call = m_pend ? m_page : CPAGE;
      case (o)
        1: m_pl[m] = nx(nx(m_pl[m]));
        2: begin m_pu[m] = pg_jmp; m_pl[m] = tpl; end
        3: begin
          r = m_pu[m] * (1 << PL_W) + nx(m_pl[m]);
          if (stk[m].size() < DEPTH) stk[m].push_front(r);
          else begin
            m_ovf[m] = 1;
            if (m == 0) begin
              void'(stk[m].pop_back());
              stk[m].push_front(r);
            end
          end
          m_pu[m] = pg_call; m_pl[m] = tpl;
        end
        4, 5: begin
          if (stk[m].size() > 0) r = stk[m].pop_front();
          else begin r = 0; m_unf[m] = 1; end
          m_pu[m] = r / (1 << PL_W);
          m_pl[m] = r % (1 << PL_W);
          if (o == 5) m_pl[m] = nx(m_pl[m]);
        end
        default: m_pl[m] = nx(m_pl[m]);
      endcase
    end
    if (a) begin
      m_pend = (o == 6);
      if (o == 6) m_page = tpu;
    end
  endtask

  task automatic step(input logic a, input logic [2:0] o, input logic [5:0] tp,
                      input logic [3:0] tu, input logic c);
    adv = a; op = o; tgt_pl = tp; tgt_pu = tu; clr_err = c;
    @(posedge clk);
    #1;
    model_step(a, int'(o), int'(tp), int'(tu), c);
    check_all();
  endtask

  // Pulse rst between edges with a CALL presented; outputs must clear with no edge.
  task automatic async_reset();
    adv = 1'b1; op = CALL; tgt_pl = 6'h15; clr_err = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    check("rst_pc_now", 32'(pc_o[0]), 32'h000);
    adv = 1'b0;
    #2 rst = 1'b0;
    step(1'b0, NEXT, 6'd0, 4'd0, 1'b0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    model_reset();
    check_all();
    #5 rst = 1'b0;

    // Polynomial counting from reset.
    step(1, NEXT, 0, 0, 0); check("next1", 32'(pc_o[0]), 32'h020);
    step(1, NEXT, 0, 0, 0); check("next2", 32'(pc_o[0]), 32'h030);
    step(1, NEXT, 0, 0, 0); check("next3", 32'(pc_o[0]), 32'h038);
    step(1, SKIP, 0, 0, 0); check("skip",  32'(pc_o[0]), 32'h03E);

    async_reset();

    // CALL/RET and CALL/RETSK from 0x038.
    repeat (3) step(1, NEXT, 0, 0, 0);
    step(1, CALL, 6'h05, 0, 0);  check("call_pc", 32'(pc_o[0]), 32'h3C5);
    step(1, RET, 0, 0, 0);       check("ret_pc",  32'(pc_o[0]), 32'h03C);
    step(1, JMP, 6'h38, 0, 0);   check("jmp_pc",  32'(pc_o[0]), 32'h038);
    step(1, CALL, 6'h05, 0, 0);
    step(1, RETSK, 0, 0, 0);     check("retsk_pc", 32'(pc_o[0]), 32'h03E);

    // Page arming is consumed by the very next instruction.
    step(1, SETPG, 0, 4'h3, 0);  check("setpg_pend", 32'(pend_o[0]), 32'h1);
    step(1, JMP, 6'h0A, 0, 0);   check("pg_jmp", 32'(pc_o[0]), 32'h0CA);
    step(1, RET, 0, 0, 0);       check("unf_pc", 32'(pc_o[0]), 32'h000);
    step(0, CALL, 0, 0, 1);
    step(1, RET, 0, 0, 1);       check("unf_beats_clr", 32'(unf_o[0]), 32'h1);
    step(0, NEXT, 0, 0, 1);
    step(1, SETPG, 0, 4'h3, 0);
    step(1, NEXT, 0, 0, 0);
    step(1, JMP, 6'h0A, 0, 0);   check("pg_dropped", 32'(pc_o[0]), 32'h00A);

    // Five nested calls: both modes overflow, with different survivors.
    for (int k = 0; k < 5; k++) begin
      ret_at[k] = m_pu[0] * (1 << PL_W) + nx(m_pl[0]);
      step(1, CALL, 6'(k + 1), 0, 0);
    end
    check("ovf_depth", 32'(depth_o[0]), 32'd4);
    check("ovf_flag1", 32'(ovf_o[1]), 32'h1);
    for (int j = 0; j < 4; j++) begin
      step(1, RET, 0, 0, 0);
      check($sformatf("ret%0d.m0", j), 32'(pc_o[0]), 32'(ret_at[4 - j]));
      check($sformatf("ret%0d.m1", j), 32'(pc_o[1]), 32'(ret_at[3 - j]));
    end
    step(1, RET, 0, 0, 0);       check("ret5_unf", 32'(unf_o[0]), 32'h1);
    step(0, NEXT, 0, 0, 1);      check("clr_ovf", 32'(ovf_o[0]), 32'h0);

    // Hold: adv low with CALL presented changes nothing.
    step(1, CALL, 6'h11, 0, 0);
    repeat (10) step(0, CALL, 6'h22, 4'h5, 0);

    // Randomised traffic against the model, with one mid-run reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_reset();
      step(($urandom_range(7) != 0), 3'($urandom_range(7)), 6'($urandom),
           4'($urandom), ($urandom_range(15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
